// File: rtl/conv_row_drain.sv
// Drains fixed-length row bursts from the pe2row output buffer into a local FIFO
// and re-emits them as a valid/ready stream with row-last and frame-first markers.
module conv_row_drain #(
    parameter  int WH             = 4,
    parameter  int IW             = 8,
    parameter  int DATA_WIDTH     = 8,
    parameter  int ROW_WORDS      = 56,
    parameter  int ROWS_PER_FRAME = 224,
    parameter  int RD_LATENCY     = 1,
    parameter  int FIFO_DEPTH     = 128,
    parameter  int GAP_CYCLES     = 2,
    localparam int WORD_W         = WH * IW * DATA_WIDTH,
    localparam int RCW            = (ROWS_PER_FRAME > 1) ? $clog2(ROWS_PER_FRAME) : 1
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              enable,
    input  logic              row_data_valid,
    output logic [WH-1:0]     row_rden,
    output logic              row_ready,
    input  logic [WORD_W-1:0] row_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [WORD_W-1:0] m_data,
    output logic              m_last,
    output logic              m_first,
    output logic [RCW-1:0]    row_count,
    output logic              frame_done
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW  = PW + 1;
    localparam int BCW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    localparam logic [CW-1:0]  DEPTH_C   = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0]  ROW_C     = CW'(ROW_WORDS);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(ROW_WORDS - 1);
    localparam logic [GCW-1:0] GAP_LAST  = GCW'(GAP_CYCLES - 1);
    localparam logic [RCW-1:0] ROW_LAST  = RCW'(ROWS_PER_FRAME - 1);

    if (FIFO_DEPTH < ROW_WORDS) begin : g_chk_depth
        $error("conv_row_drain: FIFO_DEPTH must be >= ROW_WORDS");
    end
    if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_pow2
        $error("conv_row_drain: FIFO_DEPTH must be a power of 2");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_chk_lat
        $error("conv_row_drain: RD_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;

    state_t         state_reg;
    logic           rden_reg;
    logic [BCW-1:0] beat_reg;
    logic [GCW-1:0] gap_reg;
    logic [RCW-1:0] issue_row_reg;
    logic [CW-1:0]  reserved_reg;
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [RCW-1:0] row_count_reg;
    logic           frame_done_reg;

    // Each stage carries {first, last, valid} so tags stay aligned with returning data.
    logic [RD_LATENCY-1:0][2:0] lat_pipe;
    logic [WORD_W+1:0]          mem [FIFO_DEPTH];
    logic [WORD_W+1:0]          head;

    logic burst_start;
    logic tag_last;
    logic tag_first;
    logic push;
    logic pop;

    // Space is claimed at issue time, so words in flight can never overflow the FIFO.
    assign burst_start = (state_reg == IDLE) && enable && row_data_valid &&
                         ((DEPTH_C - reserved_reg) >= ROW_C);
    assign tag_last    = (beat_reg == BEAT_LAST);
    assign tag_first   = (beat_reg == '0) && (issue_row_reg == '0);
    assign push        = lat_pipe[RD_LATENCY-1][0];
    assign pop         = m_valid && m_ready;

    for (genvar gi = 0; gi < WH; gi++) begin : g_rden
        assign row_rden[gi] = rden_reg;
    end
    assign row_ready = rden_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg     <= IDLE;
            rden_reg      <= 1'b0;
            beat_reg      <= '0;
            gap_reg       <= '0;
            issue_row_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (burst_start) begin
                        state_reg <= BURST;
                        rden_reg  <= 1'b1;
                        beat_reg  <= '0;
                    end
                end
                BURST: begin
                    if (beat_reg == BEAT_LAST) begin
                        state_reg     <= (GAP_CYCLES > 0) ? GAP : IDLE;
                        rden_reg      <= 1'b0;
                        gap_reg       <= '0;
                        issue_row_reg <= (issue_row_reg == ROW_LAST) ? '0 : issue_row_reg + RCW'(1);
                    end else begin
                        beat_reg <= beat_reg + BCW'(1);
                    end
                end
                GAP: begin
                    if (gap_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        gap_reg <= gap_reg + GCW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    rden_reg  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lat_pipe <= '0;
        end else begin
            lat_pipe[0] <= {tag_first, tag_last, rden_reg};
            for (int i = 1; i < RD_LATENCY; i++) begin
                lat_pipe[i] <= lat_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {lat_pipe[RD_LATENCY-1][1], lat_pipe[RD_LATENCY-1][2], row_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            reserved_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg    <= count_reg + CW'(push) - CW'(pop);
            reserved_reg <= reserved_reg + (burst_start ? ROW_C : '0) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_count_reg  <= '0;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;
            if (pop && m_last) begin
                if (row_count_reg == ROW_LAST) begin
                    row_count_reg  <= '0;
                    frame_done_reg <= 1'b1;
                end else begin
                    row_count_reg <= row_count_reg + RCW'(1);
                end
            end
        end
    end

    assign head       = mem[rd_ptr_reg];
    assign m_valid    = (count_reg != '0);
    assign m_data     = head[WORD_W-1:0];
    assign m_last     = m_valid && head[WORD_W+1];
    assign m_first    = m_valid && head[WORD_W];
    assign row_count  = row_count_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_conv_row_drain.sv
// Directed bench for conv_row_drain: two instances (read latency 1 and 3) share stimulus,
// each with an incrementing-pattern upstream model and an in-order stream scoreboard.
module tb_conv_row_drain;
    localparam int WH          = 2;
    localparam int IW          = 2;
    localparam int PIX_W       = 8;
    localparam int ROW_WORDS   = 4;
    localparam int ROWS        = 3;
    localparam int DEPTH       = 8;
    localparam int GAP         = 2;
    localparam int WORD_W      = WH * IW * PIX_W;
    localparam int RCW         = 2;
    localparam int FRAME_WORDS = ROW_WORDS * ROWS;
    localparam logic [WORD_W-1:0] BAD = WORD_W'(32'hDEAD_BEEF);

    logic clk            = 1'b0;
    logic rstn           = 1'b0;
    logic enable         = 1'b0;
    logic row_data_valid = 1'b0;
    logic m_ready        = 1'b0;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
        localparam int    LAT = (gi == 0) ? 1 : 3;
        localparam string PFX = (gi == 0) ? "lat1" : "lat3";

        logic [WH-1:0]     row_rden;
        logic              row_ready;
        logic [WORD_W-1:0] row_data = BAD;
        logic              m_valid;
        logic [WORD_W-1:0] m_data;
        logic              m_last;
        logic              m_first;
        logic [RCW-1:0]    row_count;
        logic              frame_done;

        logic [WORD_W-1:0] hist [LAT+1];
        int   up_cnt, exp_idx, run_len, gap_len, rden_total, pop_total, exp_row;
        logic exp_fd;

        conv_row_drain #(
            .WH(WH), .IW(IW), .DATA_WIDTH(PIX_W), .ROW_WORDS(ROW_WORDS),
            .ROWS_PER_FRAME(ROWS), .RD_LATENCY(LAT), .FIFO_DEPTH(DEPTH), .GAP_CYCLES(GAP)
        ) dut (
            .clk(clk), .rstn(rstn), .enable(enable), .row_data_valid(row_data_valid),
            .row_rden(row_rden), .row_ready(row_ready), .row_data(row_data),
            .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
            .m_first(m_first), .row_count(row_count), .frame_done(frame_done)
        );

        // Upstream model and scoreboard, evaluated mid-cycle while everything is settled.
        always @(negedge clk) begin
            if (!rstn) begin
                for (int i = 0; i <= LAT; i++) hist[i] = BAD;
                row_data   = BAD;
                up_cnt     = 0;
                exp_idx    = 0;
                run_len    = 0;
                gap_len    = GAP;
                rden_total = 0;
                pop_total  = 0;
                exp_row    = 0;
                exp_fd     = 1'b0;
            end else begin
                for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = row_rden[0] ? WORD_W'(up_cnt) : BAD;
                if (row_rden[0]) up_cnt++;
                row_data = hist[LAT];

                if (row_rden != '0) begin
                    check_value({PFX, "_rden_bits"}, row_rden, {WH{1'b1}});
                    check_value({PFX, "_row_ready"}, row_ready, 1);
                    if (run_len == 0) check_value({PFX, "_gap_len"}, gap_len >= GAP, 1);
                    run_len++;
                    rden_total++;
                    gap_len = 0;
                end else begin
                    check_value({PFX, "_row_ready_idle"}, row_ready, 0);
                    if (run_len != 0) check_value({PFX, "_burst_len"}, run_len, ROW_WORDS);
                    run_len = 0;
                    gap_len++;
                end

                check_value({PFX, "_row_count"}, row_count, exp_row);
                check_value({PFX, "_frame_done"}, frame_done, exp_fd);
                exp_fd = 1'b0;

                if (m_valid) begin
                    check_value({PFX, "_m_data"}, m_data, exp_idx);
                    check_value({PFX, "_m_last"}, m_last, (exp_idx % ROW_WORDS) == ROW_WORDS - 1);
                    check_value({PFX, "_m_first"}, m_first, (exp_idx % FRAME_WORDS) == 0);
                    if (m_ready) begin
                        if ((exp_idx % ROW_WORDS) == ROW_WORDS - 1) begin
                            if (exp_row == ROWS - 1) begin
                                exp_row = 0;
                                exp_fd  = 1'b1;
                            end else begin
                                exp_row++;
                            end
                        end
                        exp_idx++;
                        pop_total++;
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Waits for the first cycle of a fresh burst on the latency-1 instance.
    task automatic wait_burst(input string tag, input int budget);
        int k = 0;
        while (g_inst[0].row_ready && k < budget) begin tick(1); k++; end
        while (!g_inst[0].row_ready && k < budget) begin tick(1); k++; end
        check_value(tag, g_inst[0].row_ready, 1);
    endtask

    initial begin
        int fd_cnt;
        int k;
        int rden_snap;

        tick(3);
        check_value("rst_row_rden", g_inst[0].row_rden, 0);
        check_value("rst_row_ready", g_inst[0].row_ready, 0);
        check_value("rst_m_valid", g_inst[0].m_valid, 0);
        check_value("rst_m_last", g_inst[0].m_last, 0);
        check_value("rst_m_first", g_inst[0].m_first, 0);
        check_value("rst_row_count", g_inst[0].row_count, 0);
        check_value("rst_frame_done", g_inst[0].frame_done, 0);
        $display("reset values checked");

        // First burst with a free-running sink.
        rstn = 1'b1; enable = 1'b1; row_data_valid = 1'b1; m_ready = 1'b1;
        wait_burst("t1_burst_start", 10);
        tick(2);
        check_value("t1_word0_valid", g_inst[0].m_valid, 1);
        check_value("t1_word0_data", g_inst[0].m_data, 0);
        check_value("t1_word0_first", g_inst[0].m_first, 1);
        tick(3);
        check_value("t1_word3_data", g_inst[0].m_data, 3);
        check_value("t1_word3_last", g_inst[0].m_last, 1);
        tick(20);
        $display("t1 first burst: %0d words popped", g_inst[0].pop_total);

        // Stalled sink: reservation must stop issue after two bursts.
        rstn = 1'b0; m_ready = 1'b0;
        tick(2);
        rstn = 1'b1;
        tick(40);
        check_value("t2_rden_total", g_inst[0].rden_total, 8);
        check_value("t2_valid_held", g_inst[0].m_valid, 1);
        check_value("t2_data_held", g_inst[0].m_data, 0);
        tick(5);
        check_value("t2_data_still", g_inst[0].m_data, 0);
        m_ready = 1'b1;
        tick(4);
        m_ready = 1'b0;
        tick(10);
        check_value("t2_third_burst", g_inst[0].rden_total, 12);
        check_value("t2_pops", g_inst[0].pop_total, 4);
        check_value("t2_head_after", g_inst[0].m_data, 4);
        $display("t2 stall: rden cycles %0d", g_inst[0].rden_total);

        // Reset on the second cycle of a burst.
        m_ready = 1'b1;
        wait_burst("t5_burst_start", 40);
        tick(1);
        rstn = 1'b0;
        #1;
        check_value("t5_rden_cleared", g_inst[0].row_rden, 0);
        check_value("t5_valid_cleared", g_inst[0].m_valid, 0);
        check_value("t5_row_count_cleared", g_inst[0].row_count, 0);
        $display("t5 mid-burst reset applied");
        tick(1);
        rstn = 1'b1;

        // One full frame with a sink that accepts every other cycle.
        fd_cnt = 0;
        k = 0;
        while (g_inst[0].pop_total < FRAME_WORDS && k < 200) begin
            m_ready = ~m_ready;
            tick(1);
            k++;
            if (g_inst[0].frame_done) fd_cnt++;
        end
        check_value("t3_frame_words", g_inst[0].pop_total, FRAME_WORDS);
        m_ready = 1'b0;
        tick(1);
        if (g_inst[0].frame_done) fd_cnt++;
        check_value("t3_frame_done_pulses", fd_cnt, 1);
        check_value("t3_row_count_wrap", g_inst[0].row_count, 0);
        k = 0;
        while (!g_inst[0].m_valid && k < 20) begin tick(1); k++; end
        check_value("t3_word12_data", g_inst[0].m_data, FRAME_WORDS);
        check_value("t3_word12_first", g_inst[0].m_first, 1);
        $display("t3 frame: %0d words, frame_done pulses %0d", g_inst[0].pop_total, fd_cnt);

        // Dropping enable inside a burst must not truncate it.
        m_ready = 1'b1;
        wait_burst("t4_burst_start", 40);
        enable = 1'b0;
        tick(8);
        rden_snap = g_inst[0].rden_total;
        check_value("t4_burst_complete", rden_snap % ROW_WORDS, 0);
        tick(20);
        check_value("t4_no_new_burst", g_inst[0].rden_total, rden_snap);
        check_value("t4_rden_idle", g_inst[0].row_ready, 0);
        enable = 1'b1;
        wait_burst("t4_resume", 10);
        $display("t4 enable gating: rden cycles %0d", g_inst[0].rden_total);

        // Long free-running stream so the latency-3 instance covers several frames.
        tick(150);
        check_value("lat1_three_frames", g_inst[0].pop_total >= 3 * FRAME_WORDS, 1);
        check_value("lat3_three_frames", g_inst[1].pop_total >= 3 * FRAME_WORDS, 1);
        $display("stream: lat1 %0d words, lat3 %0d words", g_inst[0].pop_total, g_inst[1].pop_total);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/conv_row_drain.md
Name: conv_row_drain

Overview:
- RTL reader for the last conv layer's pe2row output interface.
- Waits for the row-valid indication, then issues fixed-length read bursts.
- Captures the returned words after the upstream read latency and buffers them in an internal FIFO.
- Presents the words as a valid/ready stream with row and frame markers, for the output DMA or the next stage.

Parameters:
- WH, 4, parallel output channels per word (Wh of the layer)
- IW, 8, pixels per channel per word (Iw of the layer)
- DATA_WIDTH, 8, bits per pixel
- ROW_WORDS, 56, words per output row burst (ceil-rounded output address count)
- ROWS_PER_FRAME, 224, output rows per frame
- RD_LATENCY, 1, cycles from row_rden high to row_data valid (1..4)
- FIFO_DEPTH, 128, internal FIFO words; power of 2; must be >= ROW_WORDS (elaboration error otherwise)
- GAP_CYCLES, 2, idle cycles after each burst so upstream valid can update

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  permits new bursts to start
- row_data_valid  in  1  upstream holds at least one complete row
- row_rden  out  WH  upstream FIFO read enables; all bits identical
- row_ready  out  1  equals row_rden[0]
- row_data  in  WH*IW*DATA_WIDTH  upstream read data, valid RD_LATENCY cycles after rden
- m_valid  out  1  stream word valid
- m_ready  in  1  stream sink ready
- m_data  out  WH*IW*DATA_WIDTH  stream word
- m_last  out  1  last word of a row
- m_first  out  1  first word of a frame
- row_count  out  clog2(ROWS_PER_FRAME)  rows fully popped in the current frame
- frame_done  out  1  one-cycle pulse after the final word of a frame is popped

Behaviour:
- Reset (async, rstn=0):
  - FSM in IDLE; row_rden=0, row_ready=0.
  - FIFO empty, reserved=0; m_valid=0, m_last=0, m_first=0.
  - row_count=0, frame_done=0; latency pipe cleared.
- Reset mid-burst aborts the burst; words already in flight are discarded. A system-wide reset of the upstream is required.
- FSM states: IDLE, BURST, GAP.
  - IDLE -> BURST when enable && row_data_valid && (FIFO_DEPTH - reserved) >= ROW_WORDS. At that edge, reserved += ROW_WORDS.
  - BURST: row_rden='1 and row_ready=1 for exactly ROW_WORDS consecutive cycles, with no gaps.
  - BURST is not affected by enable, row_data_valid or m_ready; a started burst always completes.
  - BURST -> GAP after the ROW_WORDS-th read cycle.
  - GAP: rden low for GAP_CYCLES cycles, then IDLE. There are no back-to-back bursts.
- Capture path:
  - rden[0] is delayed by a RD_LATENCY-stage shift register, with a parallel tag carrying last and first.
  - When the delayed bit is set, row_data is pushed unconditionally. The reservation guarantees the FIFO cannot overflow.
  - Tag last = final word of the burst; tag first = word 0 of row 0 of the frame.
- Output path:
  - m_valid = FIFO not empty; m_data, m_last and m_first come from the FIFO head.
  - Pop on m_valid && m_ready. Each pop does reserved -= 1.
  - Outputs hold stable while m_valid && !m_ready.
  - Same-cycle push and pop is allowed. A push into an empty FIFO appears on m_valid in the next cycle (1-cycle FIFO latency).
- Reserve update on a simultaneous burst start and pop: reserved += ROW_WORDS - 1.
- Row and frame counting:
  - row_count increments on a pop with m_last=1.
  - When row_count = ROWS_PER_FRAME-1 and that pop occurs, row_count wraps to 0 and frame_done pulses high the next cycle.
  - Burst row tracking for the first tag uses a separate issue-side counter with the same wrap.
- Burst issuance runs ahead of the output side, bounded only by FIFO reservation.

Test Plan (ROW_WORDS=4, ROWS_PER_FRAME=3, FIFO_DEPTH=8, RD_LATENCY=1, GAP_CYCLES=2, WH=2, IW=2):
- Release reset, row_data_valid=1, enable=1, m_ready=1, upstream returns an incrementing pattern -> rden high for exactly 4 cycles, low for at least 2. m_data equals 0,1,2,3 with m_last on 3. m_first on word 0 only.
- m_ready=0 with valid held high -> exactly two bursts (8 words), then no rden; m_valid stays 1 with m_data=0 stable. Raise m_ready for 4 pops -> third burst starts.
- Three rows with m_ready toggling 1/0 each cycle -> 12 words in order; row_count 1,2,0; frame_done a single pulse after word 11; m_first again on word 12.
- enable dropped on the cycle after a burst starts -> burst still completes 4 reads; no further burst until enable returns.
- rstn asserted on the 2nd burst cycle -> same cycle: rden=0, m_valid=0, row_count=0. After release, normal operation resumes from row 0.
- RD_LATENCY=3 variant -> data captured 3 cycles after each rden, with no loss or duplication over 3 frames.
